// File: rtl/seven_segment_reader.sv
// seven_segment_reader: recovers hex frames from a multiplexed active-low 7-segment bus
module seven_segment_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  frame_err
);
  localparam int EW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t                st_q, st_d;
  logic [DIGITS+6:0]     samp_q, samp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [EW-1:0]         exp_q, exp_d, dig;
  logic [4*DIGITS-1:0]   sh_nib_q, sh_nib_d, value_q, value_d;
  logic [DIGITS-1:0]     sh_err_q, sh_err_d, digit_err_q, digit_err_d;
  logic                  frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
  logic                  acc, err;
  logic [3:0]            nib;
  logic [6:0]            p;
  always_comb begin
    samp_d = {an_n, seg_n};
    cnt_d = samp_d != samp_q ? CNT_W'(1) :
            cnt_q == CNT_W'(STABLE_CYCLES) ? cnt_q : cnt_q + 1'b1;
    // fires only on the edge the count first reaches the threshold
    acc = cnt_d == CNT_W'(STABLE_CYCLES) && cnt_q != CNT_W'(STABLE_CYCLES) && $onehot(~an_n);
    p = ~seg_n;
    nib = '0;
    err = 1'b1;
    for (int i = 0; i < 16; i++)
      if (p == GLYPH[i]) begin
        nib = 4'(i);
        err = 1'b0;
      end
    dig = '0;
    for (int k = 0; k < DIGITS; k++)
      if (!an_n[k]) dig = EW'(k);
    st_d = st_q;
    exp_d = exp_q;
    sh_nib_d = sh_nib_q;
    sh_err_d = sh_err_q;
    value_d = value_q;
    digit_err_d = digit_err_q;
    frame_err_d = frame_err_q;
    frame_valid_d = 1'b0;
    case (st_q)
      IDLE:
        if (acc && dig == '0) begin
          sh_nib_d[3:0] = nib;
          sh_err_d[0] = err;
          exp_d = EW'(1);
          st_d = COLLECT;
        end
      COLLECT:
        if (acc) begin
          if (dig == exp_q) begin
            sh_nib_d[{exp_q, 2'b00} +: 4] = nib;
            sh_err_d[exp_q] = err;
            exp_d = exp_q + 1'b1;
            st_d = exp_q == EW'(DIGITS - 1) ? DONE : COLLECT;
          end else if (dig == '0) begin
            sh_nib_d[3:0] = nib;
            sh_err_d[0] = err;
            exp_d = EW'(1);
          end else begin
            sh_nib_d = '0;
            sh_err_d = '0;
            st_d = IDLE;
          end
        end
      default: begin
        value_d = sh_nib_q;
        digit_err_d = sh_err_q;
        frame_err_d = |sh_err_q;
        frame_valid_d = 1'b1;
        st_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      samp_q <= '0;
      cnt_q <= '0;
      exp_q <= '0;
      sh_nib_q <= '0;
      sh_err_q <= '0;
      value_q <= '0;
      digit_err_q <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      samp_q <= samp_d;
      cnt_q <= cnt_d;
      exp_q <= exp_d;
      sh_nib_q <= sh_nib_d;
      sh_err_q <= sh_err_d;
      value_q <= value_d;
      digit_err_q <= digit_err_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign value = value_q;
  assign digit_err = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign frame_err = frame_err_q;
endmodule
